// File: rtl/input_event_pkg.sv
// Shared types and constants for the input event generator.
//   state_e        : FSM state encoding
//   DIR_*          : bit index of each direction in the switch / pulse vectors
//   DEF_*          : default timing constants at 25 MHz
//   cnt_width()    : counter width able to hold (max_val - 1)
package input_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HELD       = 3'd1,
    ST_REPEAT     = 3'd2,
    ST_COMBO_WAIT = 3'd3,
    ST_COMBO_DONE = 3'd4,
    ST_LOCKOUT    = 3'd5
  } state_e;

  localparam int unsigned NUM_DIR   = 4;
  localparam int unsigned DIR_UP    = 0;
  localparam int unsigned DIR_DOWN  = 1;
  localparam int unsigned DIR_LEFT  = 2;
  localparam int unsigned DIR_RIGHT = 3;

  localparam logic [NUM_DIR-1:0] SW_NONE = '0;
  localparam logic [NUM_DIR-1:0] SW_ALL  = '1;

  localparam int unsigned DEF_REPEAT_DELAY  = 12500000;
  localparam int unsigned DEF_REPEAT_PERIOD = 5000000;
  localparam int unsigned DEF_COMBO_HOLD    = 25000000;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Shared hold/repeat timer: counter with synchronous clear, enable and a
// terminal-count compare against a per-state terminal value.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : synchronous clear (wins over en_i)
//   en_i         : count enable
//   term_i       : terminal count for the current state
//   done_c_o     : combinational, high while count == term_i
module hold_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             done_c_o
);

  logic [CNT_W-1:0] cnt_q;

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign done_c_o = (cnt_q == term_i);

endmodule

// File: rtl/input_event_gen.sv
// Turns the four debounced direction switches into one-cycle move pulses and
// a qualified four-switch start/pause pulse.
//   i_Clk, i_Rst           : clock, asynchronous active-high reset
//   i_Switch_1..4          : debounced Up/Down/Left/Right, high = pressed
//   o_Up/Down/Left/Right_Pulse : one-cycle move requests
//   o_Combo_Pulse          : one-cycle start/pause request
//   o_Busy                 : high whenever the FSM is not idle
// Build option: define INPUT_AUTO_REPEAT_EN to enable hold-to-repeat; without
// it every press yields exactly one move pulse.
module input_event_gen
  import input_event_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned COMBO_HOLD    = DEF_COMBO_HOLD
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  output logic o_Up_Pulse,
  output logic o_Down_Pulse,
  output logic o_Left_Pulse,
  output logic o_Right_Pulse,
  output logic o_Combo_Pulse,
  output logic o_Busy
);

  localparam int unsigned CNT_W =
    cnt_width(max3(REPEAT_DELAY, REPEAT_PERIOD, COMBO_HOLD));

  state_e             state_q;
  logic [NUM_DIR-1:0] sw_q;
  logic               sw_vld_q;
  logic [NUM_DIR-1:0] lat_q;
  logic [NUM_DIR-1:0] pulse_q;
  logic               combo_q;
  logic               busy_q;

  logic               run_c;
  logic [CNT_W-1:0]   term_c;
  logic               tmr_en_c;
  logic               tmr_clr_c;
  logic               tmr_done_c;

  // Timer runs only while a timed state keeps its qualifying input
  always_comb begin
    run_c  = 1'b0;
    term_c = '0;
    case (state_q)
`ifdef INPUT_AUTO_REPEAT_EN
      ST_HELD: begin
        run_c  = (sw_q == lat_q);
        term_c = CNT_W'(REPEAT_DELAY - 1);
      end
      ST_REPEAT: begin
        run_c  = (sw_q == lat_q);
        term_c = CNT_W'(REPEAT_PERIOD - 1);
      end
`endif
      ST_COMBO_WAIT: begin
        run_c  = (sw_q == SW_ALL);
        term_c = CNT_W'(COMBO_HOLD - 1);
      end
      default: ;
    endcase
  end

  // Clearing whenever not counting also zeroes the count on every state entry
  assign tmr_en_c  = run_c & ~tmr_done_c;
  assign tmr_clr_c = ~tmr_en_c;

  hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk_i    (i_Clk),
    .rst_i    (i_Rst),
    .clr_i    (tmr_clr_c),
    .en_i     (tmr_en_c),
    .term_i   (term_c),
    .done_c_o (tmr_done_c)
  );

  // Input register and event FSM with registered outputs.
  // sw_vld_q masks the reset value of sw_q, which is not a real sample; without
  // it a switch held through reset would look released for one cycle.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q  <= ST_LOCKOUT;
      sw_q     <= '0;
      sw_vld_q <= 1'b0;
      lat_q    <= '0;
      pulse_q  <= '0;
      combo_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      sw_q     <= {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
      sw_vld_q <= 1'b1;
      pulse_q  <= '0;
      combo_q  <= 1'b0;
      busy_q   <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (sw_q == SW_NONE) begin
            busy_q <= 1'b0;
          end else if ($onehot(sw_q)) begin
            pulse_q <= sw_q;
            lat_q   <= sw_q;
            state_q <= ST_HELD;
          end else if (sw_q == SW_ALL) begin
            state_q <= ST_COMBO_WAIT;
          end else begin
            state_q <= ST_LOCKOUT;
          end
        end
`ifdef INPUT_AUTO_REPEAT_EN
        ST_HELD, ST_REPEAT: begin
`else
        ST_HELD: begin
`endif
          if (sw_q == SW_NONE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (sw_q == SW_ALL) begin
            state_q <= ST_COMBO_WAIT;
          end else if (sw_q != lat_q) begin
            state_q <= ST_LOCKOUT;
`ifdef INPUT_AUTO_REPEAT_EN
          end else if (tmr_done_c) begin
            pulse_q <= lat_q;
            state_q <= ST_REPEAT;
`endif
          end
        end
        ST_COMBO_WAIT: begin
          if (sw_q == SW_NONE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (sw_q != SW_ALL) begin
            state_q <= ST_LOCKOUT;
          end else if (tmr_done_c) begin
            combo_q <= 1'b1;
            state_q <= ST_COMBO_DONE;
          end
        end
        ST_COMBO_DONE: begin
          if (sw_q == SW_NONE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_LOCKOUT: begin
          if (sw_vld_q && (sw_q == SW_NONE)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (sw_vld_q && (sw_q == SW_ALL)) begin
            state_q <= ST_COMBO_WAIT;
          end
        end
        default: begin
          state_q <= ST_LOCKOUT;
        end
      endcase
    end
  end

  assign o_Up_Pulse    = pulse_q[DIR_UP];
  assign o_Down_Pulse  = pulse_q[DIR_DOWN];
  assign o_Left_Pulse  = pulse_q[DIR_LEFT];
  assign o_Right_Pulse = pulse_q[DIR_RIGHT];
  assign o_Combo_Pulse = combo_q;
  assign o_Busy        = busy_q;

endmodule

// File: tb/tb_input_event_gen.sv
// Bench for input_event_gen: random and directed switch patterns, a
// press/segment-based reference model, and a per-cycle scoreboard.
module tb_input_event_gen;

  localparam int unsigned D = 8;
  localparam int unsigned P = 4;
  localparam int unsigned H = 16;
`ifdef INPUT_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0;
  logic up_p, down_p, left_p, right_p, combo_p, busy;

  input_event_gen #(
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P),
    .COMBO_HOLD    (H)
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Switch_1    (sw1),
    .i_Switch_2    (sw2),
    .i_Switch_3    (sw3),
    .i_Switch_4    (sw4),
    .o_Up_Pulse    (up_p),
    .o_Down_Pulse  (down_p),
    .o_Left_Pulse  (left_p),
    .o_Right_Pulse (right_p),
    .o_Combo_Pulse (combo_p),
    .o_Busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int up_cnt = 0, mv_cnt = 0, combo_cnt = 0;
  bit mon_en = 1'b0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_got, mon_exp;

  // Reference model: outputs follow from segments (runs of one sampled value).
  // A one-hot segment that directly follows an all-released sample is a press:
  // it pulses at offset 0 and, with auto-repeat, at D, D+P, D+2P, ...
  // An all-pressed segment fires the combo once at offset H, re-armed only by
  // a release. Anything seen before the first release after reset is locked.
  logic [3:0] m_prev;
  int         m_t;
  bit         m_locked, m_press, m_combo_done;

  task automatic model_reset();
    m_prev = 4'b0; m_t = 0; m_locked = 1'b1; m_press = 1'b0; m_combo_done = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] s, output logic [5:0] e);
    logic [3:0] mv;
    logic       cb;
    if (s != m_prev) begin
      m_t = 0;
      m_press = $onehot(s) && (m_prev == 4'b0) && !m_locked;
    end else begin
      m_t++;
    end
    if (s == 4'b0) begin
      m_locked = 1'b0;
      m_combo_done = 1'b0;
    end
    mv = 4'b0;
    if (m_press && (m_t == 0 || (AUTO && m_t >= int'(D) && ((m_t - int'(D)) % int'(P)) == 0)))
      mv = s;
    cb = 1'b0;
    if (s == 4'hF && !m_combo_done && m_t == int'(H)) begin
      cb = 1'b1;
      m_combo_done = 1'b1;
    end
    m_prev = s;
    e = {(s != 4'b0), cb, mv};
  endtask

  // Monitor: one expected output word per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      mon_got = {busy, combo_p, right_p, left_p, down_p, up_p};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow cyc=%0d got=%b", cyc, mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL sb cyc=%0d got=%b exp=%b (busy,combo,R,L,D,U)", cyc, mon_got, mon_exp);
        end
      end
      total++;
      if ($countones(mon_got[4:0]) > 1) begin
        bad++;
        $display("FAIL one_pulse cyc=%0d got=%b exp=at most one pulse", cyc, mon_got[4:0]);
      end
      up_cnt    += int'(mon_got[0]);
      mv_cnt    += $countones(mon_got[3:0]);
      combo_cnt += int'(mon_got[4]);
    end
  end

  task automatic check_cnt(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    logic [5:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      {sw4, sw3, sw2, sw1} = v;
      model_step(v, e);
      exp_q.push_back(e);
    end
  endtask

  // Assert reset with 'held' on the switches, check the immediate clear,
  // then release with the switches still at 'held'.
  task automatic do_reset(input logic [3:0] held);
    logic [5:0] e;
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    {sw4, sw3, sw2, sw1} = held;
    #1;
    total++;
    if ({busy, combo_p, right_p, left_p, down_p, up_p} !== 6'b100000) begin
      bad++;
      $display("FAIL async_rst got=%b exp=100000", {busy, combo_p, right_p, left_p, down_p, up_p});
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    exp_q.push_back(6'b100000);  // before the first edge: reset values
    exp_q.push_back(6'b100000);  // first edge: no valid sample yet
    model_step(held, e);
    exp_q.push_back(e);
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    int r, n;
    model_reset();

    // Up held through reset must not fire; then a clean Down press
    do_reset(4'b0001);
    drive(4'b0001, 5);
    drive(4'b0000, 3);
    drive(4'b0010, 3);
    drive(4'b0000, 5);

    // Hold Up for 20 cycles
    up_cnt = 0;
    drive(4'b0001, 20);
    drive(4'b0000, 6);
    check_cnt("hold20_up_pulses", up_cnt, AUTO ? 4 : 1);

    // Up then Left added: only the first Up pulse
    mv_cnt = 0;
    drive(4'b0001, 3);
    drive(4'b0101, 30);
    drive(4'b0000, 6);
    check_cnt("up_then_left_moves", mv_cnt, 1);

    // Four-switch combo held 25 cycles
    mv_cnt = 0; combo_cnt = 0;
    drive(4'b1111, 25);
    drive(4'b0000, 6);
    check_cnt("combo_pulses", combo_cnt, 1);
    check_cnt("combo_moves", mv_cnt, 0);

    // Combo broken at cycle 10
    combo_cnt = 0;
    drive(4'b1111, 10);
    drive(4'b1101, 15);
    drive(4'b0000, 6);
    check_cnt("combo_drop_pulses", combo_cnt, 0);

    // Down and Right together: locked out, no pulses
    mv_cnt = 0;
    drive(4'b1010, 6);
    drive(4'b0000, 6);
    check_cnt("two_key_moves", mv_cnt, 0);

    // Random segments with one mid-run reset
    for (int seg = 0; seg < 50; seg++) begin
      if (seg == 25) do_reset(4'($urandom_range(0, 15)));
      r = int'($urandom_range(0, 9));
      if (r <= 2)      v = 4'b0000;
      else if (r <= 6) v = 4'b0001 << $urandom_range(0, 3);
      else if (r == 7) v = 4'b1111;
      else             v = 4'($urandom_range(0, 15));
      n = int'($urandom_range(1, 26));
      drive(v, n);
    end
    drive(4'b0000, 6);

    @(negedge clk);
    @(posedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
